div_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-bit slow (restoring) divider between NREQ requesters. It accepts a divide request, issues the operands to the divider with a single-cycle start pulse, and waits for the divider's valid. It then returns quotient and remainder tagged with the requester index. It also short-circuits divide-by-zero and guards against a hung divider with a timeout.

---
 rtl/div_arbiter.sv | 147 ++++++++++++++
 tb/tb_div_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one slow divider between NREQ requesters.
// Handles divide-by-zero locally and times out a divider that never answers.
module div_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*WIDTH-1:0]     req_x,
   input  logic [NREQ*WIDTH-1:0]     req_y,
   output logic [NREQ-1:0]           req_ack,
   output logic                      busy,
   output logic                      div_start,
   output logic [WIDTH-1:0]          div_x,
   output logic [WIDTH-1:0]          div_y,
   input  logic                      div_valid,
   input  logic [WIDTH-1:0]          div_quot,
   input  logic [WIDTH-1:0]          div_rem,
   output logic                      rsp_valid,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic [WIDTH-1:0]          rsp_quot,
   output logic [WIDTH-1:0]          rsp_rem,
   output logic                      rsp_dbz,
   output logic                      rsp_err
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ZERO} state_t;

   state_t          r_state;
   logic [IDW-1:0]  r_last;
   logic [CW-1:0]   r_cnt;

   logic            w_found;
   logic [IDW-1:0]  w_idx;
   logic [IDW-1:0]  w_cand;
   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_y;

   // Round-robin search: first set request bit above the last winner.
   always_comb begin
      w_found = 1'b0;
      w_idx   = {IDW{1'b0}};
      w_cand  = {IDW{1'b0}};
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = IDW'((int'(r_last) + k) % NREQ);
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            w_idx   = w_cand;
         end else begin
            w_found = w_found;
            w_idx   = w_idx;
         end
      end
      w_x = req_x[w_idx*WIDTH +: WIDTH];
      w_y = req_y[w_idx*WIDTH +: WIDTH];
   end

   // Sequencer: grant, issue, wait for result or timeout, respond.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_last    <= IDW'(NREQ - 1);
         r_cnt     <= {CW{1'b0}};
         req_ack   <= {NREQ{1'b0}};
         busy      <= 1'b0;
         div_start <= 1'b0;
         div_x     <= {WIDTH{1'b0}};
         div_y     <= {WIDTH{1'b0}};
         rsp_valid <= 1'b0;
         rsp_id    <= {IDW{1'b0}};
         rsp_quot  <= {WIDTH{1'b0}};
         rsp_rem   <= {WIDTH{1'b0}};
         rsp_dbz   <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         req_ack   <= {NREQ{1'b0}};
         div_start <= 1'b0;
         rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  div_x   <= w_x;
                  div_y   <= w_y;
                  rsp_id  <= w_idx;
                  r_last  <= w_idx;
                  req_ack <= NREQ'(1) << w_idx;
                  busy    <= 1'b1;
                  if (w_y == {WIDTH{1'b0}}) begin
                     r_state <= S_ZERO;
                  end else begin
                     div_start <= 1'b1;
                     r_state   <= S_ISSUE;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_ISSUE: begin
               r_cnt   <= {CW{1'b0}};
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_cnt <= r_cnt + CW'(1);
               // A result arriving on the last allowed cycle still wins over the timeout.
               if (div_valid) begin
                  rsp_valid <= 1'b1;
                  rsp_quot  <= div_quot;
                  rsp_rem   <= div_rem;
                  rsp_dbz   <= 1'b0;
                  rsp_err   <= 1'b0;
                  busy      <= 1'b0;
                  r_state   <= S_IDLE;
               end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                  rsp_valid <= 1'b1;
                  rsp_quot  <= {WIDTH{1'b0}};
                  rsp_rem   <= {WIDTH{1'b0}};
                  rsp_dbz   <= 1'b0;
                  rsp_err   <= 1'b1;
                  busy      <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_ZERO: begin
               rsp_valid <= 1'b1;
               rsp_quot  <= {WIDTH{1'b1}};
               rsp_rem   <= div_x;
               rsp_dbz   <= 1'b1;
               rsp_err   <= 1'b0;
               busy      <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: divider stub plus a behavioural
// round-robin / arithmetic reference model.
module tb_div_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_r;
   logic [3:0]  opx [4];
   logic [3:0]  opy [4];
   logic [15:0] req_x_w, req_y_w;
   logic [3:0]  req_ack;
   logic        busy, div_start, div_valid, rsp_valid, rsp_dbz, rsp_err;
   logic [3:0]  div_x, div_y, div_quot, div_rem, rsp_quot, rsp_rem;
   logic [1:0]  rsp_id;

   logic        div_en = 1'b1;
   logic        manual_v = 1'b0;
   logic        stub_v = 1'b0;
   logic [2:0]  dcnt = 3'd0;
   logic [3:0]  sq = 4'd0, sr = 4'd0;

   int n_vec = 0, n_mis = 0, m_last = 3;
   int eg, ack_c, st_c, rsp_c;
   logic [3:0] ex, ey, ackv, oq, orm;
   logic [1:0] oid;
   logic bsy_a, bsy_r, odbz, oerr;

   always #5 clk = ~clk;

   assign req_x_w   = {opx[3], opx[2], opx[1], opx[0]};
   assign req_y_w   = {opy[3], opy[2], opy[1], opy[0]};
   assign div_valid = stub_v | manual_v;
   assign div_quot  = sq;
   assign div_rem   = sr;

   div_arbiter #(.NREQ(4), .WIDTH(4), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .req(req_r), .req_x(req_x_w), .req_y(req_y_w),
      .req_ack(req_ack), .busy(busy), .div_start(div_start), .div_x(div_x), .div_y(div_y),
      .div_valid(div_valid), .div_quot(div_quot), .div_rem(div_rem),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quot(rsp_quot), .rsp_rem(rsp_rem),
      .rsp_dbz(rsp_dbz), .rsp_err(rsp_err)
   );

   // Slow divider stub: result valid five cycles after the start pulse.
   always @(posedge clk) begin
      if (div_start) begin
         dcnt <= 3'd4;
         sq   <= (div_y == 4'd0) ? 4'hF : div_x / div_y;
         sr   <= (div_y == 4'd0) ? div_x : div_x % div_y;
      end else if (dcnt != 3'd0) begin
         dcnt <= dcnt - 3'd1;
      end
      stub_v <= div_en && !div_start && (dcnt == 3'd1);
   end

   function automatic int pick(input logic [3:0] r, input int last);
      for (int k = 1; k <= 4; k++)
         if (r[(last + k) % 4]) return (last + k) % 4;
      return 0;
   endfunction

   function automatic logic [9:0] exp_rsp(input logic [3:0] x, input logic [3:0] y, input logic to);
      if (to) return {1'b0, 1'b1, 4'd0, 4'd0};
      else if (y == 4'd0) return {1'b1, 1'b0, 4'd15, x};
      else return {1'b0, 1'b0, 4'(x / y), 4'(x % y)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Run one transaction from IDLE; model predicts the winner, outputs are captured.
   task automatic serve(input bit drop);
      eg = pick(req_r, m_last);
      ex = opx[eg];
      ey = opy[eg];
      m_last = eg;
      ack_c = -1; st_c = -1; rsp_c = -1; ackv = 4'd0;
      for (int c = 1; c <= 40 && rsp_c < 0; c++) begin
         step();
         if (ack_c < 0 && req_ack != 4'd0) begin
            ack_c = c; ackv = req_ack; bsy_a = busy;
            for (int i = 0; i < 4; i++) begin
               if (req_ack[i]) begin
                  if (drop) req_r[i] = 1'b0;
                  else begin opx[i] = 4'($urandom); opy[i] = 4'($urandom); end
               end
            end
         end
         if (st_c < 0 && div_start) st_c = c;
         if (rsp_valid) begin
            rsp_c = c; bsy_r = busy; oid = rsp_id; oq = rsp_quot; orm = rsp_rem;
            odbz = rsp_dbz; oerr = rsp_err;
         end
      end
      if (rsp_c < 0) begin
         n_vec++; n_mis++;
         $display("FAIL serve_bound: no rsp_valid within 40 cycles, required one");
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_r = 4'd0;
      for (int i = 0; i < 4; i++) begin opx[i] = 4'd0; opy[i] = 4'd0; end
      step(); step(); step();
      n_vec++;
      if ({req_ack, busy, div_start, div_x, div_y, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz, rsp_err} !== 27'd0) begin
         n_mis++; $display("FAIL reset_outputs: got ack=%b busy=%b start=%b rv=%b, required all zero", req_ack, busy, div_start, rsp_valid);
      end
      rst = 1'b0; m_last = 3;
      step();
      n_vec++;
      if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
   endtask

   task automatic test_round_robin();
      for (int i = 0; i < 4; i++) begin opx[i] = 4'($urandom); opy[i] = 4'($urandom_range(1, 15)); end
      req_r = 4'b1111;
      for (int k = 0; k < 12; k++) begin
         serve(k < 4);
         n_vec++;
         if (ackv !== 4'(1 << (k % 4)) || ackv !== 4'(1 << eg)) begin
            n_mis++; $display("FAIL rr_order[%0d]: got ack=%b required %b", k, ackv, 4'(1 << (k % 4)));
         end
         n_vec++;
         if ({odbz, oerr, oq, orm} !== exp_rsp(ex, ey, 1'b0) || oid !== 2'(eg)) begin
            n_mis++; $display("FAIL rr_rsp[%0d]: got id=%0d %h required id=%0d %h", k, oid, {odbz, oerr, oq, orm}, eg, exp_rsp(ex, ey, 1'b0));
         end
         if (k == 3) req_r = 4'b1111;
      end
      req_r = 4'd0;
   endtask

   task automatic test_single();
      opx[2] = 4'd13; opy[2] = 4'd4; req_r = 4'b0100;
      serve(1'b1);
      n_vec++;
      if (ackv !== 4'b0100 || ack_c != 1 || st_c != 1 || bsy_a !== 1'b1) begin
         n_mis++; $display("FAIL single_ack: got ack=%b@%0d start@%0d busy=%b, required 0100@1 start@1 busy=1", ackv, ack_c, st_c, bsy_a);
      end
      n_vec++;
      if (rsp_c != 7 || oid !== 2'd2 || oq !== 4'd3 || orm !== 4'd1 || odbz !== 1'b0 || oerr !== 1'b0 || bsy_r !== 1'b0) begin
         n_mis++; $display("FAIL single_rsp: got cyc=%0d id=%0d q=%0d r=%0d dbz=%b err=%b busy=%b, required 7 2 3 1 0 0 0", rsp_c, oid, oq, orm, odbz, oerr, bsy_r);
      end
   endtask

   task automatic test_dbz();
      opx[1] = 4'd9; opy[1] = 4'd0; req_r = 4'b0010;
      serve(1'b1);
      n_vec++;
      if (ackv !== 4'b0010 || ack_c != 1 || rsp_c != 2 || st_c != -1) begin
         n_mis++; $display("FAIL dbz_timing: got ack=%b@%0d rsp@%0d start@%0d, required 0010@1 rsp@2 no start", ackv, ack_c, rsp_c, st_c);
      end
      n_vec++;
      if (oid !== 2'd1 || odbz !== 1'b1 || oerr !== 1'b0 || oq !== 4'd15 || orm !== 4'd9) begin
         n_mis++; $display("FAIL dbz_rsp: got id=%0d dbz=%b err=%b q=%0d r=%0d, required 1 1 0 15 9", oid, odbz, oerr, oq, orm);
      end
   endtask

   task automatic test_timeout();
      div_en = 1'b0;
      opx[0] = 4'd7; opy[0] = 4'd2; req_r = 4'b0001;
      serve(1'b1);
      n_vec++;
      if (st_c != 1 || rsp_c != 17) begin
         n_mis++; $display("FAIL timeout_latency: got start@%0d rsp@%0d, required start@1 rsp@17", st_c, rsp_c);
      end
      n_vec++;
      if ({odbz, oerr, oq, orm} !== exp_rsp(ex, ey, 1'b1) || oid !== 2'd0) begin
         n_mis++; $display("FAIL timeout_rsp: got id=%0d %h required id=0 %h", oid, {odbz, oerr, oq, orm}, exp_rsp(ex, ey, 1'b1));
      end
      div_en = 1'b1;
      opx[3] = 4'd14; opy[3] = 4'd3; req_r = 4'b1000;
      serve(1'b1);
      n_vec++;
      if (rsp_c != 7 || oid !== 2'd3 || oq !== 4'd4 || orm !== 4'd2 || oerr !== 1'b0 || odbz !== 1'b0) begin
         n_mis++; $display("FAIL after_timeout: got cyc=%0d id=%0d q=%0d r=%0d err=%b dbz=%b, required 7 3 4 2 0 0", rsp_c, oid, oq, orm, oerr, odbz);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      opx[2] = 4'($urandom); opy[2] = 4'($urandom_range(1, 15)); req_r = 4'b0100;
      step();
      n_vec++;
      if (req_ack !== 4'b0100) begin n_mis++; $display("FAIL rmid_ack: got %b required 0100", req_ack); end
      req_r = 4'd0;
      step(); step(); step();
      rst = 1'b1;
      #1;
      n_vec++;
      if ({req_ack, busy, div_start, div_x, div_y, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz, rsp_err} !== 27'd0) begin
         n_mis++; $display("FAIL rmid_async: got busy=%b x=%0d y=%0d id=%0d, required all zero", busy, div_x, div_y, rsp_id);
      end
      #2;
      rst = 1'b0; m_last = 3;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (rsp_valid) seen++;
         manual_v = (c == 7);
      end
      manual_v = 1'b0;
      step();
      if (rsp_valid) seen++;
      n_vec++;
      if (seen != 0) begin n_mis++; $display("FAIL rmid_stale: got %0d rsp_valid pulses required 0", seen); end
      for (int i = 0; i < 4; i++) begin opx[i] = 4'($urandom); opy[i] = 4'($urandom_range(1, 15)); end
      req_r = 4'b1001;
      serve(1'b1);
      n_vec++;
      if (ackv !== 4'b0001 || ackv !== 4'(1 << eg) || oid !== 2'd0) begin
         n_mis++; $display("FAIL rmid_grant: got ack=%b id=%0d required 0001 id=0", ackv, oid);
      end
   endtask

   task automatic test_back_to_back();
      opx[0] = 4'($urandom); opy[0] = 4'($urandom_range(1, 15)); req_r[0] = 1'b1;
      serve(1'b1);
      n_vec++;
      if (ackv !== 4'b1000 || ackv !== 4'(1 << eg)) begin n_mis++; $display("FAIL b2b_first: got %b required 1000", ackv); end
      opx[3] = 4'($urandom); opy[3] = 4'($urandom_range(1, 15)); req_r[3] = 1'b1;
      serve(1'b1);
      n_vec++;
      if (ackv !== 4'b0001 || ackv !== 4'(1 << eg) || {odbz, oerr, oq, orm} !== exp_rsp(ex, ey, 1'b0)) begin
         n_mis++; $display("FAIL b2b_next0: got ack=%b rsp=%h required 0001 %h", ackv, {odbz, oerr, oq, orm}, exp_rsp(ex, ey, 1'b0));
      end
      serve(1'b1);
      n_vec++;
      if (ackv !== 4'b1000 || ackv !== 4'(1 << eg) || {odbz, oerr, oq, orm} !== exp_rsp(ex, ey, 1'b0)) begin
         n_mis++; $display("FAIL b2b_then3: got ack=%b rsp=%h required 1000 %h", ackv, {odbz, oerr, oq, orm}, exp_rsp(ex, ey, 1'b0));
      end
      for (int x = 0; x < 16; x++) begin
         for (int y = 1; y < 16; y++) begin
            int g;
            g = $urandom_range(0, 3);
            opx[g] = 4'(x); opy[g] = 4'(y); req_r = 4'(1 << g);
            serve(1'b1);
            n_vec++;
            if (ackv !== 4'(1 << eg) || oid !== 2'(eg) || rsp_c != 7 || {odbz, oerr, oq, orm} !== exp_rsp(ex, ey, 1'b0)) begin
               n_mis++; $display("FAIL exh x=%0d y=%0d: got ack=%b id=%0d cyc=%0d rsp=%h required id=%0d cyc=7 rsp=%h", x, y, ackv, oid, rsp_c, {odbz, oerr, oq, orm}, eg, exp_rsp(ex, ey, 1'b0));
            end
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         logic [3:0] mask;
         mask = 4'($urandom);
         if (req_r == 4'd0 && mask == 4'd0) mask = 4'b0001;
         for (int i = 0; i < 4; i++) begin
            if (mask[i] && !req_r[i]) begin
               opx[i] = 4'($urandom);
               opy[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
               req_r[i] = 1'b1;
            end
         end
         serve(1'($urandom));
         n_vec++;
         if (ackv !== 4'(1 << eg) || ack_c != 1 || rsp_c != ((ey == 4'd0) ? 2 : 7)) begin
            n_mis++; $display("FAIL rnd_grant[%0d]: got ack=%b@%0d rsp@%0d required %b@1 rsp@%0d", n, ackv, ack_c, rsp_c, 4'(1 << eg), (ey == 4'd0) ? 2 : 7);
         end
         n_vec++;
         if (oid !== 2'(eg) || {odbz, oerr, oq, orm} !== exp_rsp(ex, ey, 1'b0)) begin
            n_mis++; $display("FAIL rnd_rsp[%0d]: got id=%0d %h required id=%0d %h", n, oid, {odbz, oerr, oq, orm}, eg, exp_rsp(ex, ey, 1'b0));
         end
      end
      req_r = 4'd0;
      step(); step();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_dbz();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
